// File: rtl/debug_run_controller_pkg.sv
// Shared definitions for the debug run controller: FSM states, halt causes,
// register window offsets and CONTROL field positions.
package debug_run_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } run_state_e;

   typedef enum logic [2:0] {
      CAUSE_NONE       = 3'd0,
      CAUSE_EBREAK     = 3'd1,
      CAUSE_BREAKPOINT = 3'd2,
      CAUSE_WATCHDOG   = 3'd3,
      CAUSE_STEP       = 3'd4,
      CAUSE_COUNT_DONE = 3'd5
   } halt_cause_e;

   localparam logic [3:0] OFS_CONTROL    = 4'h0;
   localparam logic [3:0] OFS_BREAK_ADDR = 4'h4;
   localparam logic [3:0] OFS_STATUS     = 4'h8;
   localparam logic [3:0] OFS_STEP_COUNT = 4'hC;

   localparam int CTRL_BP_EN_BIT  = 0;
   localparam int CTRL_WD_EN_BIT  = 1;
   localparam int CTRL_RESUME_BIT = 2;

   function automatic logic [31:0] status_word(input halt_cause_e cause, input logic is_halted);
      return {28'd0, cause, is_halted};
   endfunction

endpackage

// File: rtl/debug_run_controller_if.sv
// Memory-mapped register bus between a bus master (CPU / debug UI) and the
// run controller's register window.
interface debug_run_controller_if;
   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_address;
   logic [31:0] bus_write_data;
   logic [31:0] bus_read_data;

   modport master (
      output bus_read, bus_write, bus_address, bus_write_data,
      input  bus_read_data
   );

   modport slave (
      input  bus_read, bus_write, bus_address, bus_write_data,
      output bus_read_data
   );
endinterface

// File: rtl/debug_run_controller_button_debouncer.sv
// Synchronises the active-low step pushbutton and emits a single-cycle pulse
// once a high-to-low transition has stayed stable for DEBOUNCE_CYCLES clocks.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic button_n_i,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync0_q;
   logic             sync1_q;
   logic             stable_q;
   logic [CNT_W-1:0] cnt_q;
   logic             press_q;

   // Idle level is high (released), so the synchroniser and the accepted
   // level both come out of reset as "not pressed".
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync0_q  <= 1'b1;
         sync1_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync0_q <= button_n_i;
         sync1_q <= sync0_q;
         press_q <= 1'b0;
         if (sync1_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync1_q;
            cnt_q    <= '0;
            press_q  <= ~sync1_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/debug_run_controller.sv
// Run-control sequencer: gates the core clock enable for free-run, halt,
// single-step and N-instruction modes, with a small register window on the bus.
module debug_run_controller
   import debug_run_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter int          WATCHDOG_MS     = 10000,
   parameter logic [31:0] BASE_ADDRESS    = 32'hFF200600
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        debug_mode,
   input  logic        step_button,
   input  logic        ebreak,
   input  logic [31:0] pc,
   input  logic        instr_retire,
   input  logic        ms_tick,
   debug_run_controller_if.slave bus,
   output logic        core_clock_enable,
   output logic        halted,
   output logic [2:0]  halt_cause
);

   run_state_e  state_q;
   halt_cause_e cause_q;
   logic        enable_q;
   logic        halted_q;
   logic        count_mode_q;
   logic [31:0] remaining_q;
   logic        skip_bp_q;
   logic [31:0] wd_count_q;

   logic        bp_enable_q;
   logic        wd_enable_q;
   logic [31:0] break_addr_q;
   logic [31:0] step_count_q;

   logic        press;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clock      (clock),
      .reset      (reset),
      .button_n_i (step_button),
      .press_o    (press)
   );

   // Address decode: offset from base must land on one of four aligned words.
   logic [31:0] offset;
   logic        in_window;
   logic [3:0]  reg_ofs;
   logic        wr_control;
   logic        wr_break_addr;
   logic        wr_step_count;
   logic        resume_req;
   logic        count_req;

   assign offset        = bus.bus_address - BASE_ADDRESS;
   assign in_window     = (offset[31:4] == 28'd0) && (offset[1:0] == 2'd0);
   assign reg_ofs       = offset[3:0];
   assign wr_control    = bus.bus_write && in_window && (reg_ofs == OFS_CONTROL);
   assign wr_break_addr = bus.bus_write && in_window && (reg_ofs == OFS_BREAK_ADDR);
   assign wr_step_count = bus.bus_write && in_window && (reg_ofs == OFS_STEP_COUNT);
   assign resume_req    = wr_control && bus.bus_write_data[CTRL_RESUME_BIT];
   assign count_req     = wr_step_count && (bus.bus_write_data != 32'd0);

   always_comb begin
      bus.bus_read_data = 32'd0;
      if (bus.bus_read && in_window) begin
         unique case (reg_ofs)
            OFS_CONTROL:    bus.bus_read_data = {30'd0, wd_enable_q, bp_enable_q};
            OFS_BREAK_ADDR: bus.bus_read_data = break_addr_q;
            OFS_STATUS:     bus.bus_read_data = status_word(cause_q, halted_q);
            OFS_STEP_COUNT: bus.bus_read_data = step_count_q;
            default:        bus.bus_read_data = 32'd0;
         endcase
      end
   end

   // Register writes commit regardless of what the FSM does in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bp_enable_q  <= 1'b0;
         wd_enable_q  <= 1'b0;
         break_addr_q <= 32'hFFFF_FFFF;
         step_count_q <= 32'd0;
      end else begin
         if (wr_control) begin
            bp_enable_q <= bus.bus_write_data[CTRL_BP_EN_BIT];
            wd_enable_q <= bus.bus_write_data[CTRL_WD_EN_BIT];
         end
         if (wr_break_addr) begin
            break_addr_q <= bus.bus_write_data;
         end
         if (count_req) begin
            step_count_q <= bus.bus_write_data;
         end
      end
   end

   // Halt detection in RUN, highest priority first.
   logic        bp_hit;
   logic        wd_hit;
   logic        halt_req_d;
   halt_cause_e halt_cause_d;

   assign bp_hit = bp_enable_q && (pc == break_addr_q) && !skip_bp_q;
   assign wd_hit = wd_enable_q && (wd_count_q >= 32'(WATCHDOG_MS));

   always_comb begin
      halt_req_d   = 1'b1;
      halt_cause_d = CAUSE_NONE;
      if (ebreak) begin
         halt_cause_d = CAUSE_EBREAK;
      end else if (bp_hit) begin
         halt_cause_d = CAUSE_BREAKPOINT;
      end else if (wd_hit) begin
         halt_cause_d = CAUSE_WATCHDOG;
      end else if (count_mode_q && instr_retire && (remaining_q == 32'd1)) begin
         halt_cause_d = CAUSE_COUNT_DONE;
      end else begin
         halt_req_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         cause_q      <= CAUSE_NONE;
         enable_q     <= 1'b1;
         halted_q     <= 1'b0;
         count_mode_q <= 1'b0;
         remaining_q  <= 32'd0;
         skip_bp_q    <= 1'b0;
         wd_count_q   <= 32'd0;
      end else begin
         if (instr_retire) begin
            skip_bp_q <= 1'b0;
         end
         if (!wd_enable_q) begin
            wd_count_q <= 32'd0;
         end else if ((state_q == ST_RUN) && ms_tick && (wd_count_q != 32'hFFFF_FFFF)) begin
            wd_count_q <= wd_count_q + 32'd1;
         end

         if (!debug_mode) begin
            if (state_q != ST_RUN) begin
               wd_count_q <= 32'd0;
            end
            if (state_q == ST_HALT) begin
               skip_bp_q <= 1'b1;
            end
            state_q      <= ST_RUN;
            enable_q     <= 1'b1;
            halted_q     <= 1'b0;
            cause_q      <= CAUSE_NONE;
            count_mode_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_RUN: begin
                  if (halt_req_d) begin
                     state_q      <= ST_HALT;
                     enable_q     <= 1'b0;
                     halted_q     <= 1'b1;
                     cause_q      <= halt_cause_d;
                     count_mode_q <= 1'b0;
                  end else if (count_mode_q && instr_retire) begin
                     remaining_q <= remaining_q - 32'd1;
                  end
               end
               ST_HALT: begin
                  if (resume_req || count_req) begin
                     state_q      <= ST_RUN;
                     enable_q     <= 1'b1;
                     halted_q     <= 1'b0;
                     skip_bp_q    <= 1'b1;
                     wd_count_q   <= 32'd0;
                     count_mode_q <= count_req;
                     if (count_req) begin
                        remaining_q <= bus.bus_write_data;
                     end
                  end else if (press) begin
                     state_q   <= ST_STEP;
                     enable_q  <= 1'b1;
                     halted_q  <= 1'b0;
                     skip_bp_q <= 1'b1;
                  end
               end
               ST_STEP: begin
                  if (ebreak || instr_retire) begin
                     state_q  <= ST_HALT;
                     enable_q <= 1'b0;
                     halted_q <= 1'b1;
                     cause_q  <= ebreak ? CAUSE_EBREAK : CAUSE_STEP;
                  end
               end
               default: begin
                  state_q  <= ST_RUN;
                  enable_q <= 1'b1;
                  halted_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign core_clock_enable = enable_q;
   assign halted            = halted_q;
   assign halt_cause        = cause_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Scoreboarded bench for debug_run_controller: breakpoint, step, count,
// watchdog, priority, debug_mode override and reset-during-step.
module tb_debug_run_controller;
   import debug_run_pkg::*;

   localparam int          DB_CYC = 20;
   localparam int          WD_MS  = 5;
   localparam logic [31:0] BASE   = 32'hFF200600;
   localparam logic [31:0] BP     = 32'h00400010;

   logic        clock = 1'b0;
   logic        reset;
   logic        debug_mode;
   logic        step_button;
   logic        ebreak;
   logic [31:0] pc;
   logic        instr_retire;
   logic        ms_tick;
   logic        core_clock_enable;
   logic        halted;
   logic [2:0]  halt_cause;

   debug_run_controller_if bus_if ();

   debug_run_controller #(
      .DEBOUNCE_CYCLES(DB_CYC),
      .WATCHDOG_MS    (WD_MS),
      .BASE_ADDRESS   (BASE)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .debug_mode        (debug_mode),
      .step_button       (step_button),
      .ebreak            (ebreak),
      .pc                (pc),
      .instr_retire      (instr_retire),
      .ms_tick           (ms_tick),
      .bus               (bus_if),
      .core_clock_enable (core_clock_enable),
      .halted            (halted),
      .halt_cause        (halt_cause)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;
   exp_t sb_q[$];

   task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end else begin
         $display("  ok   %s = 0x%08h", tag, actual);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop_check(input logic [31:0] actual);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'(sb_q.size()), 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk(e.tag, actual, e.value);
   endtask

   task automatic sig(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      sb_push(tag, expected);
      sb_pop_check(actual);
   endtask

   task automatic bus_rd(input logic [31:0] addr, input string tag, input logic [31:0] expected);
      sb_push(tag, expected);
      @(negedge clock);
      bus_if.bus_read    = 1'b1;
      bus_if.bus_address = addr;
      #1;
      sb_pop_check(bus_if.bus_read_data);
      bus_if.bus_read = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clock);
      bus_if.bus_write      = 1'b1;
      bus_if.bus_address    = addr;
      bus_if.bus_write_data = data;
      @(negedge clock);
      bus_if.bus_write = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic tick_ms();
      @(negedge clock);
      ms_tick = 1'b1;
      @(negedge clock);
      ms_tick = 1'b0;
   endtask

   task automatic pulse_ebreak();
      @(negedge clock);
      ebreak = 1'b1;
      @(negedge clock);
      ebreak = 1'b0;
   endtask

   // Simple core model: retires one instruction per enabled cycle.
   logic core_auto = 1'b0;
   int   retire_cnt = 0;
   always @(negedge clock) begin
      if (core_auto) begin
         if (instr_retire) begin
            retire_cnt++;
            pc = pc + 32'd4;
         end
         instr_retire = core_clock_enable;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit entered;
      reset                 = 1'b1;
      debug_mode            = 1'b1;
      step_button           = 1'b1;
      ebreak                = 1'b0;
      pc                    = 32'd0;
      instr_retire          = 1'b0;
      ms_tick               = 1'b0;
      bus_if.bus_read       = 1'b0;
      bus_if.bus_write      = 1'b0;
      bus_if.bus_address    = 32'd0;
      bus_if.bus_write_data = 32'd0;
      wait_cycles(3);
      reset = 1'b0;

      // Reset state
      @(negedge clock);
      sig("rst_enable", 32'(core_clock_enable), 32'd1);
      sig("rst_halted", 32'(halted), 32'd0);
      sig("rst_cause", 32'(halt_cause), 32'd0);
      bus_rd(BASE + 0,  "rst_control", 32'd0);
      bus_rd(BASE + 4,  "rst_break_addr", 32'hFFFF_FFFF);
      bus_rd(BASE + 8,  "rst_status", 32'd0);
      bus_rd(BASE + 12, "rst_step_count", 32'd0);

      // Breakpoint halt, then resume off the breakpoint PC
      bus_wr(BASE + 0, 32'h1);
      bus_wr(BASE + 4, BP);
      pc = 32'h0040_0000;
      wait_cycles(2);
      sig("bp_no_match", 32'(halted), 32'd0);
      pc = BP;
      #1;
      sig("bp_same_cycle_enable", 32'(core_clock_enable), 32'd1);
      @(negedge clock);
      sig("bp_enable_off", 32'(core_clock_enable), 32'd0);
      sig("bp_halted", 32'(halted), 32'd1);
      bus_rd(BASE + 8, "bp_status", 32'h5);
      bus_wr(BASE + 0, 32'h5);
      sig("bp_resume_enable", 32'(core_clock_enable), 32'd1);
      wait_cycles(3);
      sig("bp_skip_holds", 32'(halted), 32'd0);
      bus_rd(BASE + 8, "bp_status_running", 32'h4);
      bus_rd(BASE + 0, "control_resume_reads0", 32'h1);
      @(negedge clock);
      instr_retire = 1'b1;
      @(negedge clock);
      instr_retire = 1'b0;
      pc = BP + 32'd4;
      wait_cycles(3);
      sig("bp_past", 32'(halted), 32'd0);
      pc = BP;
      wait_cycles(2);
      sig("bp_rearmed", 32'(halted), 32'd1);
      bus_wr(BASE + 0, 32'h0);

      // Debounced single step, glitch rejection
      pc = 32'd0;
      core_auto = 1'b1;
      retire_cnt = 0;
      @(negedge clock);
      step_button = 1'b0;
      wait_cycles(10);
      step_button = 1'b1;
      wait_cycles(40);
      sig("glitch_retires", 32'(retire_cnt), 32'd0);
      sig("glitch_halted", 32'(halted), 32'd1);
      step_button = 1'b0;
      wait_cycles(2 * DB_CYC);
      step_button = 1'b1;
      wait_cycles(40);
      sig("step_retires", 32'(retire_cnt), 32'd1);
      bus_rd(BASE + 8, "step_status", 32'h9);

      // N-instruction run
      retire_cnt = 0;
      bus_wr(BASE + 12, 32'd0);
      wait_cycles(3);
      sig("count0_ignored", 32'(retire_cnt), 32'd0);
      bus_wr(BASE + 12, 32'd3);
      wait_cycles(10);
      sig("count_retires", 32'(retire_cnt), 32'd3);
      sig("count_enable", 32'(core_clock_enable), 32'd0);
      bus_rd(BASE + 8,  "count_status", 32'hB);
      bus_rd(BASE + 12, "count_readback", 32'd3);
      core_auto = 1'b0;
      @(negedge clock);
      instr_retire = 1'b0;

      // Watchdog, with restart after a halt/resume
      bus_wr(BASE + 0, 32'h6);
      for (int i = 0; i < 4; i++) tick_ms();
      sig("wd_4_ticks", 32'(halted), 32'd0);
      pulse_ebreak();
      sig("wd_ebreak_halt", 32'(halted), 32'd1);
      bus_rd(BASE + 8, "wd_ebreak_status", 32'h3);
      bus_wr(BASE + 0, 32'h6);
      for (int i = 0; i < 4; i++) tick_ms();
      sig("wd_restarted", 32'(halted), 32'd0);
      tick_ms();
      sig("wd_latency", 32'(halted), 32'd0);
      @(negedge clock);
      sig("wd_halted", 32'(halted), 32'd1);
      bus_rd(BASE + 8, "wd_status", 32'h7);

      // ebreak beats breakpoint; debug_mode=0 forces run
      pc = 32'd0;
      bus_wr(BASE + 0, 32'h5);
      @(negedge clock);
      instr_retire = 1'b1;
      @(negedge clock);
      instr_retire = 1'b0;
      pc = BP;
      ebreak = 1'b1;
      @(negedge clock);
      ebreak = 1'b0;
      sig("prio_halted", 32'(halted), 32'd1);
      bus_rd(BASE + 8, "prio_status", 32'h3);
      debug_mode = 1'b0;
      @(negedge clock);
      sig("dbg_off_enable", 32'(core_clock_enable), 32'd1);
      sig("dbg_off_halted", 32'(halted), 32'd0);
      bus_rd(BASE + 8, "dbg_off_status", 32'h0);
      bus_rd(BASE + 4, "dbg_off_regs_kept", BP);
      pc = 32'd0;
      debug_mode = 1'b1;
      bus_wr(BASE + 0, 32'h0);

      // Reset during STEP
      pulse_ebreak();
      sig("pre_step_halted", 32'(halted), 32'd1);
      step_button = 1'b0;
      entered = 1'b0;
      for (int i = 0; i < 80 && !entered; i++) begin
         @(negedge clock);
         if (core_clock_enable) entered = 1'b1;
      end
      sig("step_entered", 32'(entered), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      sig("rst_step_enable", 32'(core_clock_enable), 32'd1);
      sig("rst_step_halted", 32'(halted), 32'd0);
      step_button = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus_rd(BASE + 4,  "rst_step_break_addr", 32'hFFFF_FFFF);
      bus_rd(BASE + 16, "out_of_window_hi", 32'd0);
      bus_rd(32'd0,     "out_of_window_lo", 32'd0);
      wait_cycles(2);
      sig("rst_step_still_run", 32'(halted), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/debug_run_controller.md
# debug_run_controller

Run-control sequencer for the core clock domain. It gates the core clock enable to provide free-run, halt, single-step and N-instruction run modes. Halt sources are a hardware breakpoint, ebreak/syscall and a millisecond watchdog. It sits between the clock generator and the core, and exposes a small memory-mapped register window on the data bus so software and the debug UI can configure it.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: stable cycles required on step_button before a press is accepted.
- WATCHDOG_MS, 10000: milliseconds of continuous RUN before a watchdog halt.
- BASE_ADDRESS, 32'hFF200600: word-aligned base of the 4-register window.

Ports:
- clock  in  1  free-running reference clock; all state on posedge.
- reset  in  1  reset, asynchronous, active-high.
- debug_mode  in  1  1 = run control active; 0 = free run, halts suppressed.
- step_button  in  1  raw pushbutton, active-low, asynchronous.
- ebreak  in  1  core decoded ebreak/ecall this cycle.
- pc  in  32  current core PC.
- instr_retire  in  1  one-cycle pulse per retired instruction.
- ms_tick  in  1  one-cycle pulse per millisecond.
- bus_read, bus_write  in  1  bus strobes.
- bus_address  in  32  byte address.
- bus_write_data  in  32  write data.
- bus_read_data  out  32  read data, combinational.
- core_clock_enable  out  1  1 = core advances this cycle.
- halted  out  1  state == HALT.
- halt_cause  out  3  cause of last halt.

## Operation
- Registers at BASE+offset:
  - +0 CONTROL RW: bit0 bp_enable, bit1 wd_enable; bit2 resume, write-1 pulse, reads 0.
  - +4 BREAK_ADDR RW.
  - +8 STATUS RO: {halt_cause[3:1], halted[0]}.
  - +12 STEP_COUNT RW: writing N>0 in HALT runs N retirements, then halts.
- Reads outside the window return 0. Writes to RO fields are ignored.
- Cause codes: 0 NONE, 1 EBREAK, 2 BREAKPOINT, 3 WATCHDOG, 4 STEP, 5 COUNT_DONE.
- States:
  - RUN: enable=1.
  - HALT: enable=0.
  - STEP: enable=1 until the first instr_retire.
- RUN→HALT when debug_mode=1, on the first true condition in priority order:
  - ebreak
  - bp_enable && pc==BREAK_ADDR && !skip_bp
  - wd_enable && wd_count>=WATCHDOG_MS
  - count mode && remaining reaches 0 on retire
- HALT→RUN on resume write, or on STEP_COUNT write with N>0 (loads remaining=N, count mode on). STEP_COUNT write of 0 is ignored.
- HALT→STEP on an accepted debounced press (falling edge after DEBOUNCE_CYCLES stable high→low).
- STEP→HALT on instr_retire, cause STEP. ebreak in STEP gives cause EBREAK instead.
- skip_bp: set on every exit from HALT, cleared on the first instr_retire. This guarantees leaving a breakpoint PC.
- Watchdog: wd_count (32-bit, saturating) +1 per ms_tick while RUN and wd_enable. Cleared on entry to RUN and when wd_enable is 0.
- debug_mode=0 forces RUN, enable=1, cause=NONE and count mode off, from any state, the next cycle. Registers are preserved.
- Button presses while in RUN or STEP are discarded.

## Timing
- Reset values:
  - state RUN, core_clock_enable 1, halted 0, halt_cause 0.
  - CONTROL 0, BREAK_ADDR 32'hFFFFFFFF, STEP_COUNT 0.
  - wd_count 0, skip_bp 0, bus_read_data 0.
- Halt condition sampled at edge t: core_clock_enable=0 and halted=1 from t+1. Exactly one cycle of latency, no combinational path from inputs to enable.
- Resume or STEP_COUNT write at edge t: enable=1 from t+1.
- Register writes take effect at the writing edge. A BREAK_ADDR write in RUN is compared from the next cycle.
- Simultaneous conditions: priority above. A write to CONTROL/BREAK_ADDR in the same cycle as a halt condition still commits.
- Reset mid-STEP or mid-count: abandons the operation and returns to reset values immediately.

## Structure
- Package debug_run_pkg: state encoding, cause codes, register offsets, field bit positions.
- Sub-module button_debouncer: 2-flop synchronizer + DEBOUNCE_CYCLES counter, emits a one-cycle press pulse.
- Register file, FSM and watchdog live in the top module.

## Test plan
- bp_enable=1, BREAK_ADDR=0x00400010, PC reaches 0x00400010 -> enable=0 next cycle, STATUS=0x5. Resume -> PC advances past 0x00400010 without re-halting.
- In HALT, press held 2×DEBOUNCE_CYCLES -> exactly one retire, then HALT, STATUS=0x9. A 10-cycle glitch -> no step.
- STEP_COUNT=3 written in HALT -> exactly 3 retires, then STATUS=0xB.
- wd_enable=1, WATCHDOG_MS=5, 5 ms_ticks in RUN -> STATUS=0x7. A resume after 4 ticks restarts the count.
- ebreak and breakpoint match in the same cycle -> cause EBREAK (STATUS=0x3). Then debug_mode=0 -> enable=1, STATUS=0x0 next cycle.
- Reset asserted during STEP -> enable=1, halted=0, BREAK_ADDR read=0xFFFFFFFF, out-of-window read=0.
